fb_mem_arbiter: RTL and testbench

- Shares one single-port frame-buffer BRAM between two requesters:
  - the display scan-out fetch (read-only, latency-critical);
  - the host port behind the frame_buffer AXI4-Lite slave (read/write).
- Issues at most one memory access per cycle.
- Display has fixed priority, guarded by a starvation counter so the host always makes progress.
- Returns read data to the correct requester through a tag pipeline matched to the BRAM read latency.

---
 rtl/fb_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer BRAM arbiter: display scan-out has fixed priority, host is guaranteed a slot after
// MAX_WAIT denied cycles. Optional host stall statistics are enabled by defining FB_ARB_STATS_EN.
module fb_mem_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  disp_req,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic                  disp_ack,
    output logic                  disp_rvalid,
    output logic [DATA_W-1:0]     disp_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DATA_W-1:0]     host_wdata,
    input  logic [DATA_W/8-1:0]   host_wstrb,
    output logic                  host_ack,
    output logic                  host_rvalid,
    output logic [DATA_W-1:0]     host_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [15:0]           host_stall_cnt
);

    localparam int         STRB_W = DATA_W / 8;
    localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

    typedef enum logic [0:0] {
        NORMAL     = 1'b0,
        FORCE_HOST = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nxt;
    logic        issue_disp;
    logic        issue_host;

    // Issue stage (p0): read marker travelling with the registered memory command
    logic        vld_p0;
    logic        host_p0;

    // Return tag pipeline, one entry per BRAM latency cycle
    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] host_p;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state    <= NORMAL;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: begin
                if (disp_req && host_req && (wait_cnt + 8'd1 == MAX_W8)) begin
                    state_nxt = FORCE_HOST;
                end
            end
            FORCE_HOST: state_nxt = NORMAL;
            default:    state_nxt = NORMAL;
        endcase
    end

    // A host that withdraws its request in FORCE_HOST simply forfeits the slot
    always_comb begin
        issue_disp   = 1'b0;
        issue_host   = 1'b0;
        wait_cnt_nxt = wait_cnt;
        case (state)
            NORMAL: begin
                if (disp_req) begin
                    issue_disp   = 1'b1;
                    wait_cnt_nxt = host_req ? wait_cnt + 8'd1 : 8'd0;
                end else if (host_req) begin
                    issue_host   = 1'b1;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    wait_cnt_nxt = 8'd0;
                end
            end
            FORCE_HOST: begin
                issue_host   = host_req;
                wait_cnt_nxt = 8'd0;
            end
            default: begin
                issue_disp   = 1'b0;
                issue_host   = 1'b0;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            disp_ack  <= 1'b0;
            host_ack  <= 1'b0;
            vld_p0    <= 1'b0;
            host_p0   <= 1'b0;
        end else begin
            mem_en    <= issue_disp | issue_host;
            disp_ack  <= issue_disp;
            host_ack  <= issue_host;
            mem_we    <= (issue_host && host_we) ? host_wstrb : {STRB_W{1'b0}};
            mem_wdata <= (issue_host && host_we) ? host_wdata : {DATA_W{1'b0}};
            if (issue_host) begin
                mem_addr <= host_addr;
            end else if (issue_disp) begin
                mem_addr <= disp_addr;
            end else begin
                mem_addr <= '0;
            end
            vld_p0    <= issue_disp | (issue_host & ~host_we);
            host_p0   <= issue_host;
        end
    end

    // Tag stages p1..pRD_LAT: last entry lines up with mem_rdata
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            vld_p  <= '0;
            host_p <= '0;
        end else begin
            vld_p[0]  <= vld_p0;
            host_p[0] <= host_p0;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_p[k]  <= vld_p[k-1];
                host_p[k] <= host_p[k-1];
            end
        end
    end

    // Return stage: route registered read data to its owner
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            disp_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            disp_rdata  <= '0;
            host_rdata  <= '0;
        end else begin
            disp_rvalid <= vld_p[RD_LAT-1] & ~host_p[RD_LAT-1];
            host_rvalid <= vld_p[RD_LAT-1] &  host_p[RD_LAT-1];
            if (vld_p[RD_LAT-1] && !host_p[RD_LAT-1]) begin
                disp_rdata <= mem_rdata;
            end
            if (vld_p[RD_LAT-1] && host_p[RD_LAT-1]) begin
                host_rdata <= mem_rdata;
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            stall_cnt <= 16'h0000;
        end else if (host_req && !host_ack) begin
            stall_cnt <= sat_inc16(stall_cnt);
        end
    end

    assign host_stall_cnt = stall_cnt;
`else
    assign host_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a behavioural single-port BRAM of RD_LAT read latency.
`timescale 1ns/1ps
module tb_fb_mem_arbiter;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 32;
    localparam int LAT      = 2;
    localparam int MAX_WAIT = 15;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        disp_req = 1'b0;
    logic [10:0] disp_addr = '0;
    logic        disp_ack;
    logic        disp_rvalid;
    logic [31:0] disp_rdata;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [10:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic [3:0]  host_wstrb = '0;
    logic        host_ack;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] host_stall_cnt;

    fb_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_wstrb(host_wstrb), .host_ack(host_ack),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .host_stall_cnt(host_stall_cnt)
    );

    always #5 ACLK = ~ACLK;

    logic [31:0] mem [0:2047];
    logic [31:0] rd_pipe [0:LAT-1];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we == 4'h0) rd_pipe[0] <= mem[mem_addr];
            else                mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_we);
        end
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        both_rv = 1'b0;
    logic [31:0] disp_q[$];
    logic [31:0] host_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
        cyc++;
        if (disp_rvalid) disp_q.push_back(disp_rdata);
        if (host_rvalid) host_q.push_back(host_rdata);
        if (disp_rvalid && host_rvalid) both_rv = 1'b1;
    endtask

    // Presents a host request and retires it in the cycle its ack is seen.
    task automatic host_issue(input logic we, input logic [10:0] addr, input logic [31:0] wd,
                              input logic [3:0] st, input string tag);
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd; host_wstrb = st;
        for (int n = 0; n < 50; n++) begin
            step();
            if (host_ack) break;
        end
        check(tag, 32'(host_ack), 32'd1);
        host_req = 1'b0;
    endtask

    task automatic wait_host_rv(output int lat);
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (host_rvalid) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        seen;
        int          hacks, run_len, idle, derr, dn, hn;
        int          runs [0:2];
        logic [15:0] stall_at [0:2];
        logic        started, both_ack;
        logic [5:0]  seq;

        for (int i = 0; i < 2048; i++) mem[i] = 32'hA500_0000 | 32'(i);

        // reset held, then released with no requests
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_mem_en",   32'(mem_en), 32'd0);
        check("rst_acks",     32'({disp_ack, host_ack}), 32'd0);
        check("rst_rvalids",  32'({disp_rvalid, host_rvalid}), 32'd0);
        check("rst_rdata",    disp_rdata | host_rdata, 32'd0);
        check("rst_stall",    32'(host_stall_cnt), 32'd0);
        ARESET = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (mem_en || disp_ack || host_ack || disp_rvalid || host_rvalid) seen = 1'b1;
        end
        check("idle_activity", 32'(seen), 32'd0);
        check("idle_mem_cmd",  32'(mem_addr) | 32'(mem_we) | mem_wdata, 32'd0);

        // full write then read-after-write in the next slot
        host_issue(1'b1, 11'h010, 32'hDEADBEEF, 4'hF, "wr1_ack");
        check("wr1_mem_we",    32'(mem_we), 32'hF);
        check("wr1_mem_addr",  32'(mem_addr), 32'h010);
        check("wr1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        host_issue(1'b0, 11'h010, 32'h0, 4'h0, "rd1_ack");
        check("rd1_mem_en_we", 32'({mem_en, mem_we}), 32'h10);
        wait_host_rv(lat);
        check("rd1_latency",   32'(lat), 32'(LAT + 1));
        check("rd1_data",      host_rdata, 32'hDEADBEEF);
        repeat (4) step();
        check("rd1_host_rets", 32'(host_q.size()), 32'd1);
        check("rd1_disp_rets", 32'(disp_q.size()), 32'd0);

        // partial strobe write, then empty-strobe write that must leave memory alone
        host_issue(1'b1, 11'h010, 32'h0000AAAA, 4'b0011, "wr2_ack");
        check("wr2_mem_we",    32'(mem_we), 32'h3);
        host_issue(1'b0, 11'h010, 32'h0, 4'h0, "rd2_ack");
        wait_host_rv(lat);
        check("rd2_data",      host_rdata, 32'hDEADAAAA);
        host_issue(1'b1, 11'h010, 32'h12345678, 4'h0, "wr3_ack");
        check("wr3_mem_en_we", 32'({mem_en, mem_we}), 32'h10);
        host_issue(1'b0, 11'h010, 32'h0, 4'h0, "rd3_ack");
        wait_host_rv(lat);
        check("rd3_data",      host_rdata, 32'hDEADAAAA);
        repeat (4) step();

        // display streaming against a held host read: 15 display slots then one host slot
        disp_q.delete(); host_q.delete(); both_rv = 1'b0;
        disp_req = 1'b1; disp_addr = 11'h100;
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h010;
        hacks = 0; run_len = 0; idle = 0; started = 1'b0; both_ack = 1'b0;
        for (int n = 0; n < 80 && hacks < 3; n++) begin
            step();
            if (disp_ack && host_ack) both_ack = 1'b1;
            if (started && !disp_ack && !host_ack) idle++;
            if (disp_ack) begin
                started = 1'b1;
                run_len++;
                disp_addr = disp_addr + 11'd1;
            end
            if (host_ack) begin
                started = 1'b1;
                runs[hacks] = run_len;
                stall_at[hacks] = host_stall_cnt;
                run_len = 0;
                hacks++;
            end
        end
        host_req = 1'b0;
        disp_req = 1'b0;
        repeat (8) step();
        check("starve_host_acks", 32'(hacks), 32'd3);
        check("starve_run0",      32'(runs[0]), 32'd15);
        check("starve_run1",      32'(runs[1]), 32'd15);
        check("starve_run2",      32'(runs[2]), 32'd15);
        check("starve_idle",      32'(idle), 32'd0);
        check("starve_both_ack",  32'(both_ack), 32'd0);
        check("starve_disp_rets", 32'(disp_q.size()), 32'd45);
        derr = 0;
        foreach (disp_q[i]) if (disp_q[i] !== (32'hA500_0100 + 32'(i))) derr++;
        check("starve_disp_order", 32'(derr), 32'd0);
        check("starve_host_rets", 32'(host_q.size()), 32'd3);
        derr = 0;
        foreach (host_q[i]) if (host_q[i] !== 32'hDEADAAAA) derr++;
        check("starve_host_data", 32'(derr), 32'd0);
        check("starve_both_rv",   32'(both_rv), 32'd0);
`ifdef FB_ARB_STATS_EN
        check("stall_window1", 32'(stall_at[1] - stall_at[0]), 32'd15);
        check("stall_window2", 32'(stall_at[2] - stall_at[1]), 32'd15);
`else
        check("stall_tied_off", 32'(host_stall_cnt), 32'd0);
`endif

        // alternating display / host reads
        disp_q.delete(); host_q.delete(); both_rv = 1'b0;
        disp_addr = 11'h200; host_addr = 11'h020; host_we = 1'b0;
        disp_req = 1'b1; host_req = 1'b1;
        dn = 0; hn = 0; seq = '0;
        for (int n = 0; n < 40 && (dn < 3 || hn < 3); n++) begin
            step();
            if (disp_ack || host_ack) seq = {seq[4:0], host_ack};
            if (disp_ack) begin
                dn++;
                disp_req = 1'b0;
            end
            if (host_ack) begin
                hn++;
                if (hn < 3) begin
                    host_addr = host_addr + 11'd1;
                    disp_addr = disp_addr + 11'd1;
                    disp_req  = 1'b1;
                end else begin
                    host_req = 1'b0;
                end
            end
        end
        repeat (10) step();
        check("alt_ack_order", 32'(seq), 32'b010101);
        check("alt_disp_rets", 32'(disp_q.size()), 32'd3);
        check("alt_host_rets", 32'(host_q.size()), 32'd3);
        if (disp_q.size() == 3 && host_q.size() == 3) begin
            check("alt_disp0", disp_q[0], 32'hA500_0200);
            check("alt_disp1", disp_q[1], 32'hA500_0201);
            check("alt_disp2", disp_q[2], 32'hA500_0202);
            check("alt_host0", host_q[0], 32'hA500_0020);
            check("alt_host1", host_q[1], 32'hA500_0021);
            check("alt_host2", host_q[2], 32'hA500_0022);
        end
        check("alt_both_rv", 32'(both_rv), 32'd0);

        // asynchronous reset with two reads in flight
        disp_q.delete(); host_q.delete();
        disp_addr = 11'h300; host_addr = 11'h030;
        disp_req = 1'b1; host_req = 1'b1;
        step();
        check("mid_disp_ack", 32'(disp_ack), 32'd1);
        disp_req = 1'b0;
        step();
        check("mid_host_ack", 32'(host_ack), 32'd1);
        host_req = 1'b0;
        #2 ARESET = 1'b1;
        #1;
        check("arst_outputs", 32'({mem_en, disp_ack, host_ack, disp_rvalid, host_rvalid}), 32'd0);
        check("arst_stall",   32'(host_stall_cnt), 32'd0);
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        repeat (10) step();
        check("post_rst_disp_rets", 32'(disp_q.size()), 32'd0);
        check("post_rst_host_rets", 32'(host_q.size()), 32'd0);
        check("post_rst_stall",     32'(host_stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
